// File: rtl/token_repeat_scheduler.sv
// token_repeat_scheduler: shares one serial token-repeat line among N_REQ
// requesters. A '1' becomes REPEAT output '1's and a '0' becomes one '0'.
// Arbitration is round-robin with burst locking. Grants are throttled by the
// pending-'1' debt. An over-long burst raises a sticky overflow and freezes the block.
module token_repeat_scheduler #(
    parameter int N_REQ     = 4,
    parameter int REPEAT    = 2,
    parameter int MAX_DEBT  = 15,
    parameter int MAX_BURST = 200
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ-1:0]         req_token,
    output logic [N_REQ-1:0]         req_ready,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     b,
    output logic                     busy,
    output logic                     overflow
);
    localparam int IW = $clog2(N_REQ);
    localparam int DW = $clog2(MAX_DEBT + 1);
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] debt, debt_nxt;
    logic [IW-1:0] rr_ptr, rr_nxt;
    logic [IW-1:0] owner, owner_nxt;
    logic [BW-1:0] burst_cnt, burst_nxt;
    logic [IW-1:0] gid_nxt;
    logic          b_nxt, ovf_nxt;

    logic          rr_found;
    logic [IW-1:0] rr_win;
    logic [IW-1:0] acc_id;
    logic          can_grant, accept, acc1, acc0;
    int            idx;
    int            debt_sum;

    // Round-robin search: first valid requester at or after rr_ptr, with wrap-around
    always_comb begin
        rr_found = 1'b0;
        rr_win   = rr_ptr;
        idx      = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!rr_found && req_valid[IW'(idx)]) begin
                rr_found = 1'b1;
                rr_win   = IW'(idx);
            end
        end
    end

    // Grant generation. A new '1' raises debt by REPEAT-1 net, so that amount must still fit.
    always_comb begin
        req_ready = '0;
        can_grant = (int'(debt) + REPEAT - 1) <= MAX_DEBT;
        acc_id    = (state == IDLE) ? rr_win : owner;
        if (!overflow && can_grant) begin
            case (state)
                IDLE:    if (rr_found) req_ready[rr_win] = 1'b1;
                BURST:   if (req_valid[owner]) req_ready[owner] = 1'b1;
                default: req_ready = '0;
            endcase
        end
        accept = |req_ready;
        acc1   = accept & req_token[acc_id];
        acc0   = accept & ~req_token[acc_id];
    end

    // Next-state, debt bookkeeping and FSM transitions
    always_comb begin
        state_nxt = state;
        rr_nxt    = rr_ptr;
        owner_nxt = owner;
        burst_nxt = burst_cnt;
        gid_nxt   = grant_id;
        ovf_nxt   = overflow;
        b_nxt     = acc1 | (debt != '0);
        debt_sum  = int'(debt) + (acc1 ? REPEAT : 0) - (b_nxt ? 1 : 0);
        debt_nxt  = DW'(debt_sum);
        if (overflow) begin
            // Frozen: line held high, nothing moves until reset
            b_nxt    = 1'b1;
            debt_nxt = debt;
        end else begin
            if (accept) gid_nxt = acc_id;
            case (state)
                IDLE: begin
                    if (accept) rr_nxt = (rr_win == IW'(N_REQ - 1)) ? '0 : rr_win + 1'b1;
                    if (acc1) begin
                        owner_nxt = rr_win;
                        burst_nxt = BW'(1);
                        state_nxt = BURST;
                    end
                end
                BURST: begin
                    if (acc1) begin
                        if (burst_cnt == BW'(MAX_BURST)) ovf_nxt = 1'b1;
                        else burst_nxt = burst_cnt + 1'b1;
                    end else if (acc0) begin
                        burst_nxt = '0;
                        state_nxt = (debt_nxt != '0) ? DRAIN : IDLE;
                    end
                end
                DRAIN: begin
                    if (debt_nxt == '0) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State and output registers, asynchronously cleared
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            debt      <= '0;
            rr_ptr    <= '0;
            owner     <= '0;
            burst_cnt <= '0;
            grant_id  <= '0;
            b         <= 1'b0;
            busy      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_nxt;
            debt      <= debt_nxt;
            rr_ptr    <= rr_nxt;
            owner     <= owner_nxt;
            burst_cnt <= burst_nxt;
            grant_id  <= gid_nxt;
            b         <= b_nxt;
            busy      <= (state_nxt != IDLE);
            overflow  <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_token_repeat_scheduler.sv
// Directed bench for token_repeat_scheduler (N_REQ=4, REPEAT=2, MAX_DEBT=15, MAX_BURST=200).
module tb_token_repeat_scheduler;
    logic       clk;
    logic       rst;
    logic [3:0] req_valid;
    logic [3:0] req_token;
    logic [3:0] req_ready;
    logic [1:0] grant_id;
    logic       b, busy, overflow;

    int n_assert = 0;
    int n_fail   = 0;

    token_repeat_scheduler #(.N_REQ(4), .REPEAT(2), .MAX_DEBT(15), .MAX_BURST(200)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_token(req_token),
        .req_ready(req_ready), .grant_id(grant_id), .b(b), .busy(busy), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive, check combinational ready, clock, check registered outputs
    task automatic step(input string tag, input logic [3:0] v, input logic [3:0] t,
                        input logic [3:0] er, input logic eb, input logic ebusy);
        req_valid = v;
        req_token = t;
        #1;
        chk({tag, "_ready"}, 32'(req_ready), 32'(er));
        @(posedge clk); #1;
        chk({tag, "_b"}, 32'(b), 32'(eb));
        chk({tag, "_busy"}, 32'(busy), 32'(ebusy));
    endtask

    task automatic do_reset;
        req_valid = '0;
        req_token = '0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
    endtask

    initial begin
        int acc;
        bit seen200;
        rst = 1'b0;
        req_valid = '0;
        req_token = '0;
        #2;
        chk("rst_b", 32'(b), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_gid", 32'(grant_id), 0);
        chk("rst_ready", 32'(req_ready), 0);
        do_reset();

        // 1: req0 alone, tokens 1,0,0,1,1,0,(DRAIN, no grant),0
        step("t1c0", 4'b0001, 4'b0001, 4'b0001, 1, 1);
        step("t1c1", 4'b0001, 4'b0000, 4'b0001, 1, 0);
        step("t1c2", 4'b0001, 4'b0000, 4'b0001, 0, 0);
        step("t1c3", 4'b0001, 4'b0001, 4'b0001, 1, 1);
        step("t1c4", 4'b0001, 4'b0001, 4'b0001, 1, 1);
        step("t1c5", 4'b0001, 4'b0000, 4'b0001, 1, 1);
        step("t1c6", 4'b0001, 4'b0000, 4'b0000, 1, 0);
        step("t1c7", 4'b0001, 4'b0000, 4'b0001, 0, 0);

        // 2: all valid with token 0 -> round-robin rotation
        do_reset();
        for (int k = 0; k < 6; k++) begin
            step($sformatf("t2c%0d", k), 4'b1111, 4'b0000, 4'(1 << (k % 4)), 0, 0);
            chk($sformatf("t2gid%0d", k), 32'(grant_id), 32'(k % 4));
        end

        // 3: req0 bursts 1,1,0 while req1 waits with token 0
        do_reset();
        chk("t3_gid_rst", 32'(grant_id), 0);
        step("t3c0", 4'b0011, 4'b0001, 4'b0001, 1, 1);
        step("t3c1", 4'b0011, 4'b0001, 4'b0001, 1, 1);
        step("t3c2", 4'b0011, 4'b0000, 4'b0001, 1, 1);
        chk("t3_gid0", 32'(grant_id), 0);
        step("t3c3", 4'b0010, 4'b0000, 4'b0000, 1, 0);
        step("t3c4", 4'b0010, 4'b0000, 4'b0010, 0, 0);
        chk("t3_gid1", 32'(grant_id), 1);

        // 4: continuous 1s -> debt saturates at 15 and ready alternates
        do_reset();
        for (int c = 0; c < 20; c++) begin
            step($sformatf("t4c%0d", c), 4'b0001, 4'b0001,
                 (c < 15 || (c % 2) == 0) ? 4'b0001 : 4'b0000, 1, 1);
        end

        // 5: 201 consecutive 1s -> overflow after the 201st accept
        do_reset();
        req_valid = 4'b0001;
        req_token = 4'b0001;
        acc = 0;
        seen200 = 0;
        for (int c = 0; c < 1000 && acc < 201; c++) begin
            #1;
            if (req_ready[0]) acc++;
            @(posedge clk); #1;
            if (acc == 200 && !seen200) begin
                seen200 = 1;
                chk("t5_ovf_at200", 32'(overflow), 0);
            end
        end
        chk("t5_accepts", 32'(acc), 201);
        chk("t5_ovf", 32'(overflow), 1);
        chk("t5_b", 32'(b), 1);
        req_valid = 4'b1111;
        req_token = 4'b0000;
        #1;
        chk("t5_ready0", 32'(req_ready), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("t5_ready1", 32'(req_ready), 0);
        chk("t5_b_hold", 32'(b), 1);
        chk("t5_ovf_hold", 32'(overflow), 1);
        rst = 1'b0;
        #1;
        chk("t5_ovf_clr", 32'(overflow), 0);
        chk("t5_b_clr", 32'(b), 0);

        // 6: async reset mid-burst with debt 5
        do_reset();
        for (int c = 0; c < 5; c++)
            step($sformatf("t6c%0d", c), 4'b0001, 4'b0001, 4'b0001, 1, 1);
        #3 rst = 1'b0;
        #1;
        chk("t6_b", 32'(b), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_ovf", 32'(overflow), 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        step("t6_post", 4'b1111, 4'b0000, 4'b0001, 0, 0);
        chk("t6_gid", 32'(grant_id), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
